// File: rtl/dht_proto_pkg.sv
// Shared DHT11 host-protocol definitions: command and reply codes, sequencer
// state encoding, and the reply-selection function used by the sequencer.
package dht_proto_pkg;

    // Host command codes
    localparam logic [7:0] CMD_STATUS = 8'hAC;
    localparam logic [7:0] CMD_TEMP   = 8'h01;
    localparam logic [7:0] CMD_HUM    = 8'h02;
    localparam logic [7:0] CMD_CONT_T = 8'h03;
    localparam logic [7:0] CMD_STOP_T = 8'h04;
    localparam logic [7:0] CMD_CONT_H = 8'h05;
    localparam logic [7:0] CMD_STOP_H = 8'h06;

    // Reply codes (first byte of every reply)
    localparam logic [7:0] RSP_STATUS_OK = 8'h07;
    localparam logic [7:0] RSP_HUM       = 8'h08;
    localparam logic [7:0] RSP_TEMP      = 8'h09;
    localparam logic [7:0] RSP_CONT_T    = 8'h0A;
    localparam logic [7:0] RSP_CONT_H    = 8'h0B;
    localparam logic [7:0] RSP_STOP      = 8'h0C;
    localparam logic [7:0] RSP_NO_DATA   = 8'h1F;
    localparam logic [7:0] RSP_UNKNOWN   = 8'hFF;

    // Sequencer state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_BUILD = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_WAIT0 = 3'd3;
    localparam logic [2:0] ST_WAIT1 = 3'd4;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_TEMP = 2'd1,
        MODE_HUM  = 2'd2
    } contModeT;

    typedef struct packed {
        logic [7:0] humInt;
        logic [7:0] humDec;
        logic [7:0] tempInt;
        logic [7:0] tempDec;
        logic [7:0] checksum;
    } dhtFrameT;

    typedef struct packed {
        logic [7:0] byte0;
        logic [7:0] byte1;
    } replyT;

    // Maps a command to its two reply bytes given the latest snapshot.
    function automatic replyT replySelect(input logic [7:0] code,
                                          input logic [7:0] addr,
                                          input dhtFrameT   snapshot,
                                          input logic       snapOk);
        replyT    r;
        // decimal bytes and checksum play no part in any reply
        dhtFrameT unusedSnap;
        unusedSnap = snapshot;
        r.byte0 = RSP_UNKNOWN;
        r.byte1 = code;
        case (code)
            CMD_STATUS: begin
                r.byte0 = snapOk ? RSP_STATUS_OK : RSP_NO_DATA;
                r.byte1 = addr;
            end
            CMD_TEMP: begin
                r.byte0 = snapOk ? RSP_TEMP : RSP_NO_DATA;
                r.byte1 = snapOk ? snapshot.tempInt : 8'h00;
            end
            CMD_HUM: begin
                r.byte0 = snapOk ? RSP_HUM : RSP_NO_DATA;
                r.byte1 = snapOk ? snapshot.humInt : 8'h00;
            end
            CMD_CONT_T: begin
                r.byte0 = RSP_CONT_T;
                r.byte1 = 8'h00;
            end
            CMD_CONT_H: begin
                r.byte0 = RSP_CONT_H;
                r.byte1 = 8'h00;
            end
            CMD_STOP_T, CMD_STOP_H: begin
                r.byte0 = RSP_STOP;
                r.byte1 = 8'h00;
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dht_frame_checker.sv
// Holds the most recent DHT11 frame and whether its checksum matched.
module dht_frame_checker
    import dht_proto_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        sensorValid,
    input  logic [39:0] sensorFrame,
    output dhtFrameT    snapFrame,
    output logic        snapOk
);

    // Byte sum of the four data bytes, modulo 256, against the checksum byte.
    function automatic logic checksumOk(input dhtFrameT f);
        logic [7:0] sum;
        sum = f.humInt + f.humDec + f.tempInt + f.tempDec;
        return sum == f.checksum;
    endfunction

    // Frame data is captured on every sensor pulse and carries no reset.
    always_ff @(posedge clock) begin
        if (sensorValid) snapFrame <= dhtFrameT'(sensorFrame);
    end

    // Validity flag stays low until the first frame arrives.
    always_ff @(posedge clock) begin
        if (reset)            snapOk <= 1'b0;
        else if (sensorValid) snapOk <= checksumOk(dhtFrameT'(sensorFrame));
    end

endmodule

// File: rtl/dht_tx_response_sequencer.sv
// Builds the two-byte reply for each host command (or periodic continuous
// reading), launches the downstream transmitter and waits for both bytes.
// CONT_PERIOD must be at least 2.
module dht_tx_response_sequencer
    import dht_proto_pkg::*;
#(
    parameter int CONT_PERIOD = 50_000_000,
    parameter int TX_TIMEOUT  = 200_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [7:0]  req_code,
    input  logic [7:0]  req_addr,
    output logic        req_ready,
    input  logic        sensor_valid,
    input  logic [39:0] sensor_frame,
    output logic        tx_start,
    output logic [7:0]  tx_byte0,
    output logic [7:0]  tx_byte1,
    input  logic        tx_busy,
    input  logic        tx_done,
    output logic        cont_active,
    output logic        tx_error
);

    localparam logic [25:0] CONT_LAST    = 26'(CONT_PERIOD - 1);
    localparam logic [25:0] CONT_PRELAST = 26'(CONT_PERIOD - 2);
    localparam int          WD_W         = $clog2(TX_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TX_TIMEOUT);

    logic [2:0]      state;
    logic [WD_W-1:0] wdog;
    logic [25:0]     periodCnt;
    logic            contPend;
    contModeT        contMode;
    logic            doneLast;
    dhtFrameT        snapFrame;
    logic            snapOk;
    logic            accept, contFire, doneRise, wdogExpired;
    logic            isEnable, isDisable;
    replyT           reqReply, contReply;
    // the transmitter's busy flag is informational; progress is tracked on tx_done
    logic            unusedBusy;

    dht_frame_checker u_checker (
        .clock       (clock),
        .reset       (reset),
        .sensorValid (sensor_valid),
        .sensorFrame (sensor_frame),
        .snapFrame   (snapFrame),
        .snapOk      (snapOk)
    );

    assign unusedBusy  = tx_busy;
    assign req_ready   = (state == ST_IDLE);
    assign tx_start    = (state == ST_START);
    assign cont_active = (contMode != MODE_OFF);

    // Request arbitration (host wins over a pending periodic reply) and reply selection.
    always_comb begin
        accept      = req_valid && (state == ST_IDLE);
        contFire    = (state == ST_IDLE) && !req_valid && contPend;
        doneRise    = tx_done && !doneLast;
        wdogExpired = (wdog == WD_LIMIT);
        isEnable    = (req_code == CMD_CONT_T) || (req_code == CMD_CONT_H);
        isDisable   = (req_code == CMD_STOP_T) || (req_code == CMD_STOP_H);
        reqReply    = replySelect(req_code, req_addr, snapFrame, snapOk);
        contReply   = replySelect((contMode == MODE_HUM) ? CMD_HUM : CMD_TEMP,
                                  8'h00, snapFrame, snapOk);
    end

    // Previous tx_done level, so a long done pulse counts only once.
    always_ff @(posedge clock) begin
        if (reset) doneLast <= 1'b0;
        else       doneLast <= tx_done;
    end

    // Reply bytes are captured at acceptance and held until the next request.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_byte0 <= 8'h00;
            tx_byte1 <= 8'h00;
        end else if (accept) begin
            tx_byte0 <= reqReply.byte0;
            tx_byte1 <= reqReply.byte1;
        end else if (contFire) begin
            tx_byte0 <= contReply.byte0;
            tx_byte1 <= contReply.byte1;
        end
    end

    // Sequencer: build, launch, then count two done edges under a watchdog.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            wdog     <= '0;
            tx_error <= 1'b0;
        end else begin
            tx_error <= 1'b0;
            case (state)
                ST_IDLE:  if (accept || contFire) state <= ST_BUILD;
                ST_BUILD: state <= ST_START;
                ST_START: begin
                    wdog  <= '0;
                    state <= ST_WAIT0;
                end
                ST_WAIT0, ST_WAIT1: begin
                    if (wdogExpired) begin
                        tx_error <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                        if (doneRise) state <= (state == ST_WAIT0) ? ST_WAIT1 : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Continuous mode: period counter parks at its last value while a reply
    // is still pending, so overlapping expirations collapse into one.
    always_ff @(posedge clock) begin
        if (reset) begin
            contMode  <= MODE_OFF;
            periodCnt <= '0;
            contPend  <= 1'b0;
        end else if (accept && isEnable) begin
            contMode  <= (req_code == CMD_CONT_H) ? MODE_HUM : MODE_TEMP;
            periodCnt <= '0;
            contPend  <= 1'b0;
        end else if ((accept && isDisable) || (contMode == MODE_OFF)) begin
            contMode  <= MODE_OFF;
            periodCnt <= '0;
            contPend  <= 1'b0;
        end else begin
            if (contFire) contPend <= 1'b0;
            if (periodCnt == CONT_LAST) begin
                if (!contPend || contFire) periodCnt <= '0;
            end else begin
                periodCnt <= periodCnt + 1'b1;
                if (periodCnt == CONT_PRELAST) contPend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dht_tx_response_sequencer.sv
// Directed/randomized bench for the DHT reply sequencer with a reference
// model of the reply table, snapshot checksum and continuous-mode timing.
module tb_dht_tx_response_sequencer;

    localparam int CONT_PERIOD = 100;
    localparam int TX_TIMEOUT  = 50;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [7:0]  req_code = 8'h00;
    logic [7:0]  req_addr = 8'h00;
    logic        req_ready;
    logic        sensor_valid = 1'b0;
    logic [39:0] sensor_frame = '0;
    logic        tx_start;
    logic [7:0]  tx_byte0, tx_byte1;
    logic        tx_busy = 1'b0;
    logic        tx_done = 1'b0;
    logic        cont_active;
    logic        tx_error;

    int nAsserts = 0;
    int nFails   = 0;
    int cyc      = 0;

    // Reference model state
    logic [7:0]  mBytes [5];
    logic        mOk     = 1'b0;
    int          mMode   = 0;   // 0 off, 1 temperature, 2 humidity
    logic [15:0] expHeld = 16'h0000;

    dht_tx_response_sequencer #(
        .CONT_PERIOD (CONT_PERIOD),
        .TX_TIMEOUT  (TX_TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_code     (req_code),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .sensor_valid (sensor_valid),
        .sensor_frame (sensor_frame),
        .tx_start     (tx_start),
        .tx_byte0     (tx_byte0),
        .tx_byte1     (tx_byte1),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .cont_active  (cont_active),
        .tx_error     (tx_error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, observed cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp)
        else begin
            nFails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reply table as a lookup on the model snapshot.
    function automatic logic [15:0] modelReply(input logic [7:0] code, input logic [7:0] addr);
        logic [15:0] r;
        if (code == 8'hAC)                       r = {(mOk ? 8'h07 : 8'h1F), addr};
        else if (code == 8'h01)                  r = mOk ? {8'h09, mBytes[2]} : 16'h1F00;
        else if (code == 8'h02)                  r = mOk ? {8'h08, mBytes[0]} : 16'h1F00;
        else if (code == 8'h03)                  r = 16'h0A00;
        else if (code == 8'h05)                  r = 16'h0B00;
        else if (code == 8'h04 || code == 8'h06) r = 16'h0C00;
        else                                     r = {8'hFF, code};
        return r;
    endfunction

    task automatic sendFrame(input logic [39:0] f);
        int sum;
        sensor_valid = 1'b1;
        sensor_frame = f;
        tick();
        sensor_valid = 1'b0;
        for (int i = 0; i < 5; i++) mBytes[i] = f[39-8*i -: 8];
        sum = mBytes[0] + mBytes[1] + mBytes[2] + mBytes[3];
        mOk = ((sum % 256) == mBytes[4]);
    endtask

    // Issue a host request and check the fixed 2-cycle latency to tx_start.
    task automatic sendReq(input logic [7:0] code, input logic [7:0] addr, input string tag);
        logic [15:0] exp;
        int w;
        w = 0;
        while (!req_ready && w < 300) begin tick(); w++; end
        check({tag, "_ready_before"}, req_ready, 1);
        exp = modelReply(code, addr);
        if (code == 8'h03) mMode = 1;
        if (code == 8'h05) mMode = 2;
        if (code == 8'h04 || code == 8'h06) mMode = 0;
        req_valid = 1'b1;
        req_code  = code;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
        check({tag, "_ready_n1"}, req_ready, 0);
        check({tag, "_start_n1"}, tx_start, 0);
        check({tag, "_bytes_n1"}, {tx_byte0, tx_byte1}, exp);
        check({tag, "_cont_n1"}, cont_active, (mMode != 0));
        tick();
        check({tag, "_start_n2"}, tx_start, 1);
        check({tag, "_bytes_n2"}, {tx_byte0, tx_byte1}, exp);
        tx_busy = 1'b1;
        expHeld = exp;
    endtask

    task automatic pulseDone(input int gap, input int len);
        repeat (gap) tick();
        tx_done = 1'b1;
        repeat (len) tick();
        tx_done = 1'b0;
    endtask

    // Two 2-cycle done pulses; ready must return only after the second edge.
    task automatic serveTwo(input string tag);
        pulseDone(3, 2);
        repeat (3) tick();
        check({tag, "_ready_between"}, req_ready, 0);
        tx_done = 1'b1;
        check({tag, "_ready_at_edge2"}, req_ready, 0);
        check({tag, "_bytes_held"}, {tx_byte0, tx_byte1}, expHeld);
        tick();
        check({tag, "_ready_after"}, req_ready, 1);
        tick();
        tx_done = 1'b0;
        tx_busy = 1'b0;
    endtask

    task automatic waitStart(input int bound, output logic found);
        int w;
        w = 0;
        while (!tx_start && w < bound) begin tick(); w++; end
        found = tx_start;
    endtask

    initial begin
        logic        found;
        logic [7:0]  b [4];
        logic [7:0]  cs, code;
        int          sum, sIdx, interval, cnt, errCnt;
        logic        readyAtErr;
        logic [39:0] f;

        // Reset state
        repeat (3) tick();
        check("rst_ready", req_ready, 1);
        check("rst_start", tx_start, 0);
        check("rst_error", tx_error, 0);
        check("rst_cont", cont_active, 0);
        check("rst_bytes", {tx_byte0, tx_byte1}, 16'h0000);
        reset = 1'b0;
        tick();

        // No frame ever received
        sendReq(8'h7E, 8'h33, "noframe_unknown");
        serveTwo("noframe_unknown");
        sendReq(8'h01, 8'h00, "noframe_temp");
        serveTwo("noframe_temp");

        // Good frame, temperature
        sendFrame({8'h32, 8'h00, 8'h19, 8'h00, 8'h4B});
        sendReq(8'h01, 8'h00, "temp_good");
        check("temp_good_value", expHeld, 16'h0919);
        serveTwo("temp_good");

        // Bad checksum frame
        sendFrame({8'h32, 8'h00, 8'h19, 8'h00, 8'h00});
        sendReq(8'hAC, 8'h05, "status_bad");
        check("status_bad_value", expHeld, 16'h1F05);
        serveTwo("status_bad");
        sendReq(8'h02, 8'h00, "hum_bad");
        serveTwo("hum_bad");

        // Randomized frames and commands; a new frame lands mid-transmission
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                for (int k = 0; k < 4; k++) b[k] = 8'($urandom_range(0, 99));
                sum = b[0] + b[1] + b[2] + b[3];
                cs  = 8'(sum);
                if ($urandom_range(0, 1) == 0) cs = cs ^ 8'h5A;
                sendFrame({b[0], b[1], b[2], b[3], cs});
            end
            case ($urandom_range(0, 3))
                0:       code = 8'hAC;
                1:       code = 8'h01;
                2:       code = 8'h02;
                default: code = 8'($urandom_range(7, 255));
            endcase
            sendReq(code, 8'($urandom_range(0, 255)), "rand");
            for (int k = 0; k < 4; k++) b[k] = 8'($urandom_range(0, 99));
            sum = b[0] + b[1] + b[2] + b[3];
            sendFrame({b[0], b[1], b[2], b[3], 8'(sum)});
            serveTwo("rand");
        end

        // Continuous humidity mode
        sendFrame({8'h37, 8'h00, 8'h15, 8'h00, 8'h4C});
        sendReq(8'h05, 8'h00, "cont_enable");
        serveTwo("cont_enable");
        waitStart(150, found);
        check("cont_first_found", found, 1);
        check("cont_first_bytes", {tx_byte0, tx_byte1}, 16'h0837);
        expHeld = 16'h0837;
        sIdx = cyc;
        tx_busy = 1'b1;
        serveTwo("cont_first");
        waitStart(150, found);
        interval = cyc - sIdx;
        check("cont_second_found", found, 1);
        check("cont_interval_in_range", (interval >= 95 && interval <= 105), 1);
        check("cont_second_bytes", {tx_byte0, tx_byte1}, 16'h0837);
        sIdx = cyc;
        tx_busy = 1'b1;
        serveTwo("cont_second");

        // Host request spans the next expiry; a second host request collides
        // with the pending periodic reply and must go first.
        while (cyc < sIdx + 75) tick();
        sendReq(8'h02, 8'h00, "cont_slow_host");
        pulseDone(15, 2);
        repeat (15) tick();
        req_valid = 1'b1;
        req_code  = 8'h01;
        req_addr  = 8'h00;
        tx_done   = 1'b1;
        tick();
        tx_done = 1'b0;
        check("collide_ready_idle", req_ready, 1);
        tick();
        req_valid = 1'b0;
        check("collide_host_bytes", {tx_byte0, tx_byte1}, 16'h0915);
        tick();
        check("collide_host_start", tx_start, 1);
        expHeld = 16'h0915;
        tx_busy = 1'b1;
        serveTwo("collide_host");
        waitStart(30, found);
        check("collide_cont_found", found, 1);
        check("collide_cont_bytes", {tx_byte0, tx_byte1}, 16'h0837);
        expHeld = 16'h0837;
        tx_busy = 1'b1;
        serveTwo("collide_cont");

        // Disable and confirm silence
        sendReq(8'h06, 8'h00, "cont_disable");
        serveTwo("cont_disable");
        cnt = 0;
        repeat (250) begin
            if (tx_start) cnt++;
            tick();
        end
        check("cont_stopped_starts", cnt, 0);

        // Watchdog abort with only one done pulse
        sendReq(8'h01, 8'h00, "timeout");
        pulseDone(2, 2);
        errCnt = 0;
        readyAtErr = 1'b0;
        repeat (80) begin
            if (tx_error) begin
                errCnt++;
                readyAtErr = req_ready;
            end
            tick();
        end
        tx_busy = 1'b0;
        check("timeout_error_count", errCnt, 1);
        check("timeout_idle_at_error", readyAtErr, 1);
        sendReq(8'h02, 8'h00, "after_timeout");
        serveTwo("after_timeout");

        // Reset while waiting for the second byte
        f = {8'h28, 8'h00, 8'h11, 8'h00, 8'h39};
        sendFrame(f);
        sendReq(8'h05, 8'h00, "rstmid_enable");
        serveTwo("rstmid_enable");
        sendReq(8'h01, 8'h00, "rstmid");
        pulseDone(2, 2);
        repeat (2) tick();
        check("rstmid_in_wait1", req_ready, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mOk   = 1'b0;
        mMode = 0;
        check("rstmid_ready", req_ready, 1);
        check("rstmid_start", tx_start, 0);
        check("rstmid_error", tx_error, 0);
        check("rstmid_cont", cont_active, 0);
        check("rstmid_bytes", {tx_byte0, tx_byte1}, 16'h0000);
        tx_busy = 1'b0;
        tx_done = 1'b1;
        cnt = 0;
        repeat (2) begin
            if (tx_start) cnt++;
            tick();
        end
        tx_done = 1'b0;
        repeat (10) begin
            if (tx_start) cnt++;
            tick();
        end
        check("rstmid_late_done_no_start", cnt, 0);
        sendReq(8'h01, 8'h00, "after_reset_temp");
        check("after_reset_value", expHeld, 16'h1F00);
        serveTwo("after_reset_temp");

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/dht_tx_response_sequencer.md
# dht_tx_response_sequencer

Builds the two-byte reply for each host command and hands it to the serial transmitter directly downstream. Selects reply codes and payload from the latest latched DHT11 frame, validates the frame checksum, and optionally re-sends temperature or humidity periodically in continuous mode. Drives the transmitter's start/byte inputs and tracks its completion pulses until both bytes are out.

## Interface
- `CONT_PERIOD`, default 50_000_000: clock cycles between continuous-mode replies (1 s at 50 MHz).
- `TX_TIMEOUT`, default 200_000: maximum cycles from `tx_start` to the second completion before abort.
- `clock` input 1: single system clock. All logic is on the rising edge.
- `reset` input 1: reset is synchronous and active-high.
- `req_valid` input 1: a host command is present.
- `req_code` input 8: command byte.
- `req_addr` input 8: sensor address byte. It is echoed in status replies.
- `req_ready` output 1: high only in IDLE. A request is accepted when `req_valid && req_ready`.
- `sensor_valid` input 1: one-cycle pulse; `sensor_frame` is new.
- `sensor_frame` input 40: {hum_int, hum_dec, temp_int, temp_dec, checksum}, MSB first.
- `tx_start` output 1: one-cycle pulse that launches a two-byte transmission.
- `tx_byte0`, `tx_byte1` output 8 each: reply bytes. They are held stable from `tx_start` until return to IDLE.
- `tx_busy` input 1: transmitter active.
- `tx_done` input 1: high for ≥1 cycle after each byte's stop bit.
- `cont_active` output 1: continuous mode is enabled.
- `tx_error` output 1: one-cycle pulse when a timeout abort occurs.

## Operation
- Snapshot register:
  - On `sensor_valid`, latch `sensor_frame` and set `snap_ok` = (byte sum of the four data bytes mod 256 == checksum).
  - `snap_ok` = 0 until the first pulse.
  - A `sensor_valid` pulse arriving during a transmission updates the snapshot but never changes the held `tx_byte0/1`.
- Commands, giving {byte0, byte1}:
  - 0xAC status: {0x07, req_addr} if `snap_ok`, else {0x1F, req_addr}.
  - 0x01 temperature: {0x09, temp_int}.
  - 0x02 humidity: {0x08, hum_int}.
  - 0x03: enable continuous temperature, reply {0x0A, 0x00}.
  - 0x05: enable continuous humidity, reply {0x0B, 0x00}.
  - 0x04 / 0x06: disable continuous mode, reply {0x0C, 0x00}. Either code disables either mode.
  - Any other code: {0xFF, req_code}.
  - For 0x01, 0x02 and continuous replies, if `snap_ok` = 0 the reply is {0x1F, 0x00}.
- Continuous mode:
  - The period counter runs while `cont_active` and reloads to 0 on enable.
  - On reaching CONT_PERIOD−1, set `cont_pend`.
  - In IDLE with `cont_pend` set, emit the temperature or humidity reply per the mode and clear `cont_pend`.
  - A host request presented in the same cycle wins; `cont_pend` stays set.
  - Multiple expirations while busy collapse into one pending reply.
- FSM states:
  - IDLE: on accept or `cont_pend`, go to BUILD.
  - BUILD: register `tx_byte0/1`, then go to START.
  - START: pulse `tx_start`, clear the done counter and watchdog, then go to WAIT0.
  - WAIT0: on a rising edge of `tx_done` (registered previous value), go to WAIT1.
  - WAIT1: on the next rising edge of `tx_done`, go to IDLE.
  - Watchdog reaching TX_TIMEOUT in WAIT0/WAIT1: pulse `tx_error`, go to IDLE.
- Edge detection on `tx_done` means a multi-cycle done level counts once.
- `tx_busy` is informational only. The FSM never advances on it.

## Timing
- Reset values:
  - `req_ready` = 1.
  - `tx_start` = 0, `tx_error` = 0, `cont_active` = 0.
  - `tx_byte0/1` = 0x00.
  - `snap_ok` = 0, `cont_pend` = 0, state IDLE, counters 0.
- Reset mid-transmission returns to IDLE immediately. The transmitter completes its frame, and its trailing `tx_done` edges are ignored in IDLE.
- Latency is fixed at 2 cycles: accept in cycle N → bytes valid at N+1 → `tx_start` high at N+2.
- `req_ready` is low from N+1 until the cycle after the second `tx_done` rising edge, inclusive of abort.
- Mode changes from 0x03–0x06 take effect in the BUILD cycle.
- The period counter is 26 bits wide and saturates at CONT_PERIOD−1 while `cont_pend` is set.

## Structure
- Shared package `dht_proto_pkg` holds:
  - Command codes 0xAC, 0x01–0x06.
  - Reply codes 0x07, 0x08, 0x09, 0x0A, 0x0B, 0x0C, 0x1F, 0xFF.
  - FSM state encoding.
  - A reply-select function taking (code, addr, snapshot, snap_ok) and returning {byte0, byte1}.
- One sub-module, `dht_frame_checker`, contains the snapshot register, checksum compare and `snap_ok`.

## Test plan
- Frame {0x32, 0x00, 0x19, 0x00, 0x4B}, then request 0x01 → `tx_start` 2 cycles after accept with bytes {0x09, 0x19}. Two `tx_done` pulses, each 2 cycles long → `req_ready` returns after the second rising edge.
- Frame with checksum 0x00, then request 0xAC with addr 0x05 → {0x1F, 0x05}. Request 0x02 → {0x1F, 0x00}.
- No frame ever, request 0x7E → {0xFF, 0x7E}.
- CONT_PERIOD=100: request 0x05 → {0x0B, 0x00}, then {0x08, hum_int} every ~100 cycles. A host request 0x01 collides with expiry → the host reply goes first, then the continuous reply. Request 0x06 → {0x0C, 0x00} and periodic replies stop.
- TX_TIMEOUT=50 with only one `tx_done` → `tx_error` pulses exactly once, FSM is back in IDLE, and a new request is accepted.
- Assert `reset` in WAIT1 → all outputs reach reset values next cycle. A late `tx_done` produces no `tx_start`.
